// File: rtl/handshake_arb.sv
// Round-robin arbiter that funnels NUM_REQ valid/ready masters into one registered
// output stage, locking a winner for up to MAX_BURST consecutive beats.
module handshake_arb #(
   parameter int WIDTH     = 32,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4,
   localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       valid_i,
   output logic [NUM_REQ-1:0]       ready_o,
   input  logic [NUM_REQ*WIDTH-1:0] data_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [SRC_W-1:0]         src_o
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state_q, state_d;
   logic [SRC_W-1:0]   ptr_q, ptr_d;
   logic [SRC_W-1:0]   gnt_q, gnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SRC_W-1:0]   src_q, src_d;

   logic               out_free;
   logic               win_valid;
   logic [SRC_W-1:0]   win_idx;
   logic               xfer;
   int                 idx;

   function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + SRC_W'(1);
   endfunction

   assign out_free = !valid_q || ready_i;

   // Winner selection: locked master during a burst, otherwise first valid from ptr.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      idx       = 0;
      if (state_q == BURST) begin
         win_valid = valid_i[gnt_q];
         win_idx   = gnt_q;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_valid && valid_i[idx]) begin
               win_valid = 1'b1;
               win_idx   = SRC_W'(idx);
            end
         end
      end
   end

   always_comb begin
      ready_o = '0;
      xfer    = !rst && win_valid && out_free;
      if (xfer) ready_o[win_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;

      if (xfer) begin
         valid_d = 1'b1;
         data_d  = data_i[int'(win_idx)*WIDTH +: WIDTH];
         src_d   = win_idx;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end

      // A stalled beat (out_free low) leaves the burst budget untouched.
      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (MAX_BURST == 1) begin
                  ptr_d = wrap_inc(win_idx);
               end else begin
                  state_d = BURST;
                  gnt_d   = win_idx;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         BURST: begin
            if (!valid_i[gnt_q]) begin
               state_d = IDLE;
               ptr_d   = wrap_inc(gnt_q);
            end else if (xfer) begin
               if (int'(cnt_q) + 1 == MAX_BURST) begin
                  state_d = IDLE;
                  ptr_d   = wrap_inc(gnt_q);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign src_o   = src_q;

endmodule

// File: tb/tb_handshake_arb.sv
// Self-checking bench for handshake_arb: directed vector table, hand-written corner
// sequences and a random phase, all scored against a behavioural arbiter model.
module tb_handshake_arb;

   localparam int WIDTH     = 32;
   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 4;
   localparam int SRC_W     = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       valid_i;
   logic [NUM_REQ-1:0]       ready_o;
   logic [NUM_REQ*WIDTH-1:0] data_i;
   logic                     valid_o;
   logic                     ready_i;
   logic [WIDTH-1:0]         data_o;
   logic [SRC_W-1:0]         src_o;

   always #5 clk = ~clk;

   handshake_arb #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .src_o(src_o)
   );

   typedef struct {
      logic               rst;
      logic [NUM_REQ-1:0] valid;
      logic               rdy;
      logic [NUM_REQ-1:0] exp_ready;
      logic               exp_valid;
      logic [SRC_W-1:0]   exp_src;
   } vec_t;

   typedef struct {
      int               src;
      logic [WIDTH-1:0] data;
   } beat_t;

   vec_t  vecs[16];
   beat_t sb[$];
   int    checks = 0;
   int    passed = 0;

   // Behavioural reference of the arbiter
   bit    m_burst = 0;
   int    m_ptr = 0, m_gnt = 0, m_cnt = 0;
   bit    m_valid = 0;
   bit    m_rst_seen = 1;
   logic [NUM_REQ-1:0] last_ready;
   bit    rand_phase = 0;
   int    exp_seq[NUM_REQ];
   int    wait_beats[NUM_REQ];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int modelWinner(input logic [NUM_REQ-1:0] v);
      if (m_burst) return v[m_gnt] ? m_gnt : -1;
      for (int i = 0; i < NUM_REQ; i++) begin
         int k;
         k = (m_ptr + i) % NUM_REQ;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic applyStimulus(input logic r, input logic [NUM_REQ-1:0] v, input logic rdy,
                                input logic [NUM_REQ*WIDTH-1:0] d);
      rst     = r;
      valid_i = v;
      ready_i = rdy;
      data_i  = d;
   endtask

   // One clock cycle: compare at the falling edge, then advance the model over the rising edge.
   task automatic runCycle(input bit use_tab, input int vi);
      int                 win;
      logic [NUM_REQ-1:0] exp_ready;
      beat_t              b;
      @(negedge clk);
      win       = modelWinner(valid_i);
      exp_ready = (!rst && win >= 0 && (!m_valid || ready_i)) ? (NUM_REQ'(1) << win) : '0;
      checkOutput("onehot_ready", 64'($onehot0(ready_o)), 64'd1);
      if (use_tab) begin
         checkOutput($sformatf("tab%0d_ready", vi), 64'(ready_o), 64'(vecs[vi].exp_ready));
         checkOutput($sformatf("tab%0d_valid", vi), 64'(valid_o), 64'(vecs[vi].exp_valid));
         if (vecs[vi].exp_valid)
            checkOutput($sformatf("tab%0d_src", vi), 64'(src_o), 64'(vecs[vi].exp_src));
      end else begin
         checkOutput("ready_o", 64'(ready_o), 64'(exp_ready));
         checkOutput("valid_o", 64'(valid_o), 64'(m_valid));
      end
      if (m_rst_seen) begin
         checkOutput("rst_data", 64'(data_o), 64'd0);
         checkOutput("rst_src", 64'(src_o), 64'd0);
      end
      if (!rst && valid_o === 1'b1 && ready_i) begin
         if (sb.size() == 0) checkOutput("sb_underflow", 64'd1, 64'd0);
         else begin
            b = sb.pop_front();
            checkOutput("sb_data", 64'(data_o), 64'(b.data));
            checkOutput("sb_src", 64'(src_o), 64'(b.src));
            if (rand_phase) begin
               checkOutput("order", 64'(data_o[23:0]), 64'(exp_seq[b.src]));
               exp_seq[b.src]++;
            end
         end
      end
      last_ready = exp_ready;
      if (rst) begin
         m_burst = 0; m_ptr = 0; m_gnt = 0; m_cnt = 0; m_valid = 0; m_rst_seen = 1;
         sb.delete();
      end else begin
         m_rst_seen = 0;
         if (exp_ready != 0) begin
            sb.push_back('{win, data_i[win*WIDTH +: WIDTH]});
            if (rand_phase) begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  if (k == win || !valid_i[k]) wait_beats[k] = 0;
                  else begin
                     wait_beats[k]++;
                     checkOutput($sformatf("starve%0d", k),
                                 64'(wait_beats[k] <= (NUM_REQ-1)*MAX_BURST), 64'd1);
                  end
               end
            end
         end
         m_valid = (exp_ready != 0) ? 1'b1 : (ready_i ? 1'b0 : m_valid);
         if (!m_burst) begin
            if (exp_ready != 0) begin
               if (MAX_BURST == 1) m_ptr = (win + 1) % NUM_REQ;
               else begin m_burst = 1; m_gnt = win; m_cnt = 1; end
            end
         end else if (!valid_i[m_gnt]) begin
            m_burst = 0; m_ptr = (m_gnt + 1) % NUM_REQ;
         end else if (exp_ready != 0) begin
            if (m_cnt + 1 == MAX_BURST) begin m_burst = 0; m_ptr = (m_gnt + 1) % NUM_REQ; end
            else m_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NUM_REQ*WIDTH-1:0] randData();
      logic [NUM_REQ*WIDTH-1:0] d;
      for (int k = 0; k < NUM_REQ; k++) d[k*WIDTH +: WIDTH] = $urandom;
      return d;
   endfunction

   task automatic handSeq(input logic r, input logic [NUM_REQ-1:0] v, input logic rdy, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(r, v, rdy, randData());
         runCycle(1'b0, 0);
      end
   endtask

   logic [NUM_REQ*WIDTH-1:0] tab_data;
   logic [NUM_REQ-1:0]       pend;
   int                       seq[NUM_REQ];
   logic [NUM_REQ*WIDTH-1:0] rd;

   initial begin
      vecs[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
      vecs[1]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0};
      vecs[2]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
      vecs[3]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
      vecs[4]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
      vecs[5]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0};
      vecs[6]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
      vecs[7]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
      vecs[8]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
      vecs[9]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1};
      vecs[10] = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
      vecs[11] = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2};
      vecs[12] = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2};
      vecs[13] = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2};
      vecs[14] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2};
      vecs[15] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0};
      tab_data = {32'h33333333, 32'hA5A5A5A5, 32'h11111111, 32'h0F0F0F0F};

      applyStimulus(1'b1, '0, 1'b0, '0);
      @(posedge clk);
      #1;
      $display("[TB] vector table");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].rdy, tab_data);
         runCycle(1'b1, i);
      end

      $display("[TB] backpressure mid-burst");
      handSeq(1'b1, 4'h0, 1'b1, 1);
      handSeq(1'b0, 4'h2, 1'b1, 2);
      handSeq(1'b0, 4'h3, 1'b0, 3);
      handSeq(1'b0, 4'h3, 1'b1, 4);
      handSeq(1'b0, 4'h0, 1'b1, 2);

      $display("[TB] valid drop with pointer wrap");
      handSeq(1'b1, 4'h0, 1'b1, 1);
      handSeq(1'b0, 4'h8, 1'b1, 2);
      handSeq(1'b0, 4'h1, 1'b1, 3);
      handSeq(1'b0, 4'h0, 1'b1, 2);

      $display("[TB] reset mid-burst");
      handSeq(1'b1, 4'h0, 1'b1, 1);
      handSeq(1'b0, 4'h4, 1'b1, 2);
      handSeq(1'b1, 4'h4, 1'b0, 1);
      handSeq(1'b0, 4'hF, 1'b1, 3);
      handSeq(1'b0, 4'h0, 1'b1, 2);

      $display("[TB] random traffic");
      handSeq(1'b1, 4'h0, 1'b1, 1);
      rand_phase = 1;
      pend = '0;
      for (int k = 0; k < NUM_REQ; k++) begin seq[k] = 0; exp_seq[k] = 0; wait_beats[k] = 0; end
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!pend[k]) pend[k] = ($urandom_range(0, 99) < 60);
            rd[k*WIDTH +: WIDTH] = {8'(k), 24'(seq[k])};
         end
         applyStimulus(1'b0, pend, ($urandom_range(0, 99) < 75), rd);
         runCycle(1'b0, 0);
         for (int k = 0; k < NUM_REQ; k++) begin
            if (last_ready[k]) begin
               seq[k]++;
               pend[k] = 1'b0;
            end
         end
      end
      applyStimulus(1'b0, '0, 1'b1, '0);
      runCycle(1'b0, 0);
      runCycle(1'b0, 0);
      checkOutput("drain", 64'(sb.size()), 64'd0);
      for (int k = 0; k < NUM_REQ; k++)
         checkOutput($sformatf("beats%0d", k), 64'(exp_seq[k]), 64'(seq[k]));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/handshake_arb.md
HANDSHAKE_ARB -- requirements
Module: handshake_arb

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesting masters (2..16).
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive beats granted to one master (1..255).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port valid_i  input  NUM_REQ  per-master valid; bit k from master k.
REQ-007 Port ready_o  output  NUM_REQ  per-master ready; bit k to master k.
REQ-008 Port data_i  input  NUM_REQ*WIDTH  per-master payload; master k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port valid_o  output  1  registered valid to slave.
REQ-010 Port ready_i  input  1  ready from slave.
REQ-011 Port data_o  output  WIDTH  registered payload to slave.
REQ-012 Port src_o  output  clog2(NUM_REQ) (min 1)  registered index of the master that supplied data_o.

Function
REQ-013 Transfer on master side k: valid_i[k] && ready_o[k] at a rising edge; slave side: valid_o && ready_i.
REQ-014 Output stage SHALL be one register; out_free = !valid_o || ready_i.
REQ-015 Master transfer SHALL load data_o/src_o and set valid_o=1 next cycle; latency exactly 1 cycle.
REQ-016 Slave transfer with no master transfer in the same cycle SHALL clear valid_o next cycle.
REQ-017 While valid_o=1 and ready_i=0, valid_o, data_o and src_o SHALL hold unchanged.
REQ-018 At most one ready_o bit SHALL be high in any cycle; ready_o[k]=1 only if k is the current winner and out_free=1.
REQ-019 ready_o SHALL be combinational from registered state, valid_i and ready_i; it SHALL NOT depend on data_i.
REQ-020 FSM states: IDLE, BURST; internal ptr (round-robin start, 0..NUM_REQ-1), gnt (locked master), cnt (beats in burst).
REQ-021 IDLE: winner = first k with valid_i[k]=1 searching ptr, ptr+1, ... modulo NUM_REQ; no valid_i -> no winner, ready_o=0.
REQ-022 IDLE, winner transfers: if MAX_BURST=1 stay IDLE and ptr <= winner+1 mod NUM_REQ; else go BURST, gnt <= winner, cnt <= 1.
REQ-023 IDLE, winner present but out_free=0: stay IDLE, ptr unchanged; winner re-evaluated next cycle.
REQ-024 BURST: winner = gnt regardless of other valid_i bits.
REQ-025 BURST, transfer with cnt+1 == MAX_BURST: go IDLE, ptr <= gnt+1 mod NUM_REQ.
REQ-026 BURST, transfer with cnt+1 < MAX_BURST: stay BURST, cnt <= cnt+1.
REQ-027 BURST, valid_i[gnt]=0: go IDLE, ptr <= gnt+1 mod NUM_REQ, no transfer that cycle.
REQ-028 BURST, valid_i[gnt]=1 but out_free=0: stay BURST, cnt unchanged (backpressure does not consume budget).
REQ-029 Simultaneous slave and master transfer SHALL keep valid_o=1 and load new data (full throughput, one beat per cycle).
REQ-030 Wrap-around: ptr = NUM_REQ-1 plus grant SHALL wrap ptr to 0.
REQ-031 Masters not granted SHALL see ready_o=0 and their data SHALL NOT reach data_o.

Reset
REQ-032 rst=1 at a rising edge: valid_o=0, data_o=0, src_o=0, state IDLE, ptr=0, gnt=0, cnt=0.
REQ-033 While rst=1, ready_o SHALL be 0 on all bits.
REQ-034 rst SHALL override every concurrent event; reset mid-burst discards the held output beat and restarts fairness at master 0.

Verification
REQ-035 Reset, then valid_i=4'b1111, ready_i=1, MAX_BURST=4 -> src_o sequence 0,0,0,0,1,1,1,1,2,..., one beat per cycle, first valid_o one cycle after first ready_o.
REQ-036 Only master 2 valid, data 0xA5A5A5A5, ready_i=1 -> ready_o=4'b0100, data_o=0xA5A5A5A5, src_o=2 next cycle.
REQ-037 Master 1 bursting, ready_i=0 for 3 cycles after beat 2 -> data_o/src_o held, cnt stays 2, burst resumes and ends after beat 4.
REQ-038 Master 3 drops valid after 2 beats, master 0 valid -> next grant master 0 (ptr wrapped 3->0), one idle slave cycle allowed.
REQ-039 rst asserted mid-burst with valid_o=1 -> next cycle valid_o=0, data_o=0, ready_o=0; after release first grant goes to lowest valid index from 0.
REQ-040 Random valid_i/ready_i, 10k cycles -> no beat lost/duplicated per master, per-master order kept, at most one ready_o high, no master starved beyond (NUM_REQ-1)*MAX_BURST granted beats.
